fan_rev_timer: RTL and testbench

- Front end of the LED fan's hall-sensor (`fanclk`) interface: the producer side of the angular timing that the pattern blocks (smile, cute, playboy, dim) consume.
- Synchronises the raw `fanclk` pulse, rejects glitches and measures the revolution period in `clk` cycles.
- Slices each revolution into 2^COL_BITS equal columns, emitting a column index and column strobe that pattern blocks use to drive `led`.
- Detects a stopped or too-slow fan and drops lock.

---
 rtl/fan_pkg.sv | 12 +
 rtl/fan_rev_timer_if.sv | 24 ++
 rtl/fan_edge_sync.sv | 22 ++
 rtl/fan_rev_timer.sv | 133 +++++++++++++
 tb/tb_fan_rev_timer.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared constants for the fan hall-sensor timing blocks
package fan_pkg;

  localparam int FAN_CNT_W    = 27;
  localparam int FAN_COL_BITS = 7;
  localparam int NUM_COLS     = 1 << FAN_COL_BITS;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

endpackage

// File: rtl/fan_rev_timer_if.sv
// rtl/fan_rev_timer_if.sv - hall-sensor input and angular timing outputs
interface fan_rev_timer_if
  import fan_pkg::*;
#(
  parameter int CNT_W    = FAN_CNT_W,
  parameter int COL_BITS = FAN_COL_BITS
);
  logic                fanclk;
  logic                rev_stb;
  logic                locked;
  logic [CNT_W-1:0]    period;
  logic [COL_BITS-1:0] col_idx;
  logic                col_stb;

  modport master (
    output fanclk,
    input  rev_stb, locked, period, col_idx, col_stb
  );

  modport slave (
    input  fanclk,
    output rev_stb, locked, period, col_idx, col_stb
  );
endinterface

// File: rtl/fan_edge_sync.sv
// rtl/fan_edge_sync.sv - 2-flop synchroniser plus rising-edge detect
module fan_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic edge_o
);
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b00;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign edge_o = sync_q[1] & ~prev_q;
endmodule

// File: rtl/fan_rev_timer.sv
// rtl/fan_rev_timer.sv - revolution period measurement, glitch filter,
// stall detection and column slicing for the LED fan
module fan_rev_timer
  import fan_pkg::*;
#(
  parameter int CNT_W      = FAN_CNT_W,
  parameter int COL_BITS   = FAN_COL_BITS,
  parameter int MIN_PERIOD = 10000,
  parameter int MAX_PERIOD = 100000000
) (
  input  logic           clk,
  input  logic           rst,
  fan_rev_timer_if.slave bus
);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    MAX_C    = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W:0]      MIN_C    = (CNT_W+1)'(MIN_PERIOD);
  localparam logic [COL_BITS-1:0] COL_ONE  = COL_BITS'(1);
  localparam logic [COL_BITS-1:0] LAST_COL = '1;

  logic                edge_ev;
  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d;
  logic [CNT_W-1:0]    period_q, period_d;
  logic [CNT_W-1:0]    col_len_q, col_len_d;
  logic [CNT_W-1:0]    ccnt_q, ccnt_d;
  logic [COL_BITS-1:0] col_idx_q, col_idx_d;
  logic                locked_q, locked_d;
  logic                rev_stb_q, rev_stb_d;
  logic                col_stb_q, col_stb_d;

  logic [CNT_W:0]      pcnt_inc;
  logic [CNT_W-1:0]    measured;
  logic [CNT_W-1:0]    len_shift;
  logic [CNT_W-1:0]    len_new;
  logic [CNT_W-1:0]    pcnt_sat;
  logic                accept;
  logic                stall;

  fan_edge_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.fanclk),
    .edge_o  (edge_ev)
  );

  // Wide increment so the glitch compare cannot overflow at saturation.
  assign pcnt_inc  = {1'b0, pcnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign measured  = pcnt_inc[CNT_W-1:0];
  assign len_shift = measured >> COL_BITS;
  assign len_new   = (len_shift == '0) ? CNT_ONE : len_shift;
  assign pcnt_sat  = (pcnt_q == MAX_C) ? pcnt_q : pcnt_q + CNT_ONE;
  assign accept    = edge_ev && ((state_q == ST_IDLE) || (pcnt_inc >= MIN_C));
  assign stall     = (state_q != ST_IDLE) && !accept && (pcnt_sat == MAX_C);

  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    period_d  = period_q;
    col_len_d = col_len_q;
    ccnt_d    = ccnt_q;
    col_idx_d = col_idx_q;
    locked_d  = locked_q;
    rev_stb_d = 1'b0;
    col_stb_d = 1'b0;

    if (accept) begin
      rev_stb_d = 1'b1;
      pcnt_d    = '0;
      if (state_q == ST_IDLE) begin
        state_d = ST_MEASURE;
      end else begin
        state_d   = ST_RUN;
        period_d  = measured;
        col_len_d = len_new;
        locked_d  = 1'b1;
        ccnt_d    = '0;
        col_idx_d = '0;
        col_stb_d = 1'b1;
      end
    end else if (stall) begin
      state_d   = ST_IDLE;
      pcnt_d    = '0;
      period_d  = '0;
      col_len_d = '0;
      locked_d  = 1'b0;
      ccnt_d    = '0;
      col_idx_d = '0;
    end else if (state_q != ST_IDLE) begin
      pcnt_d = pcnt_sat;
      // Columns stop at the last one and wait for the next revolution edge.
      if (state_q == ST_RUN && col_idx_q != LAST_COL) begin
        if (ccnt_q == col_len_q - CNT_ONE) begin
          ccnt_d    = '0;
          col_idx_d = col_idx_q + COL_ONE;
          col_stb_d = 1'b1;
        end else begin
          ccnt_d = ccnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pcnt_q    <= '0;
      period_q  <= '0;
      col_len_q <= '0;
      ccnt_q    <= '0;
      col_idx_q <= '0;
      locked_q  <= 1'b0;
      rev_stb_q <= 1'b0;
      col_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      period_q  <= period_d;
      col_len_q <= col_len_d;
      ccnt_q    <= ccnt_d;
      col_idx_q <= col_idx_d;
      locked_q  <= locked_d;
      rev_stb_q <= rev_stb_d;
      col_stb_q <= col_stb_d;
    end
  end

  assign bus.rev_stb = rev_stb_q;
  assign bus.locked  = locked_q;
  assign bus.period  = period_q;
  assign bus.col_idx = col_idx_q;
  assign bus.col_stb = col_stb_q;
endmodule

// File: tb/tb_fan_rev_timer.sv
// tb/tb_fan_rev_timer.sv - self-checking bench for fan_rev_timer
module tb_fan_rev_timer;
  localparam int CNT_W = 12;
  localparam int COL_BITS = 2;
  localparam int MIN_P = 4;
  localparam int MAX_P = 1000;
  localparam int SYNC_LAT = 3;

  typedef struct packed {
    int   cyc;
    logic rev;
    logic col;
    int   idx;
    int   per;
    logic lk;
  } ev_t;

  typedef struct {
    int gap;
    bit glitch;
    bit exp_lk;
    int exp_per;
    int exp_ncols;
    int exp_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];
  vec_t vecs[7];

  fan_rev_timer_if #(.CNT_W(CNT_W), .COL_BITS(COL_BITS)) bus ();

  fan_rev_timer #(
    .CNT_W(CNT_W), .COL_BITS(COL_BITS), .MIN_PERIOD(MIN_P), .MAX_PERIOD(MAX_P)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {49'd0, bus.rev_stb, bus.col_stb, bus.locked, bus.period, bus.col_idx};
  endfunction

  task automatic monitor();
    ev_t got;
    ev_t exp;
    forever begin
      @(negedge clk);
      if (!rst && (bus.rev_stb || bus.col_stb)) begin
        got.cyc = cyc;
        got.rev = bus.rev_stb;
        got.col = bus.col_stb;
        got.idx = int'(bus.col_idx);
        got.per = int'(bus.period);
        got.lk  = bus.locked;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got cyc=%0d rev=%0b col=%0b idx=%0d per=%0d lk=%0b required none",
                   got.cyc, got.rev, got.col, got.idx, got.per, got.lk);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            fails++;
            $display("FAIL strobe_event: got cyc=%0d rev=%0b col=%0b idx=%0d per=%0d lk=%0b required cyc=%0d rev=%0b col=%0b idx=%0d per=%0d lk=%0b",
                     got.cyc, got.rev, got.col, got.idx, got.per, got.lk,
                     exp.cyc, exp.rev, exp.col, exp.idx, exp.per, exp.lk);
          end
        end
      end
    end
  endtask

  task automatic push_exp(input int c, input vec_t v);
    ev_t e;
    e.cyc = c + SYNC_LAT;
    e.rev = 1'b1;
    e.col = v.exp_lk;
    e.idx = 0;
    e.per = v.exp_per;
    e.lk  = v.exp_lk;
    exp_q.push_back(e);
    for (int k = 1; k < v.exp_ncols; k++) begin
      e.cyc = c + SYNC_LAT + k * v.exp_len;
      e.rev = 1'b0;
      e.col = 1'b1;
      e.idx = k;
      exp_q.push_back(e);
    end
  endtask

  // Called on a falling clock edge; returns on the falling edge gap cycles later.
  task automatic run_vec(input vec_t v);
    int c;
    c = cyc;
    push_exp(c, v);
    bus.fanclk = 1'b1;
    @(negedge clk);
    bus.fanclk = 1'b0;
    @(negedge clk);
    if (v.glitch) begin
      bus.fanclk = 1'b1;
      @(negedge clk);
      bus.fanclk = 1'b0;
    end
    while (cyc < c + v.gap) begin
      @(negedge clk);
      if (v.gap > MAX_P && cyc == c + SYNC_LAT + MAX_P - 1)
        check("pre_stall_locked", 64'(bus.locked), 64'd1);
      if (v.gap > MAX_P && cyc == c + SYNC_LAT + MAX_P)
        check("stall_cleared", all_outs(), 64'd0);
    end
    if (v.exp_ncols > 0 && v.gap <= MAX_P)
      check("col_idx_hold", 64'(bus.col_idx), 64'(v.exp_ncols - 1));
  endtask

  initial begin
    vec_t rv;
    int   c;

    vecs[0] = '{400,  1'b0, 1'b0, 0,   0, 0};
    vecs[1] = '{400,  1'b0, 1'b1, 400, 4, 100};
    vecs[2] = '{400,  1'b1, 1'b1, 400, 4, 100};
    vecs[3] = '{300,  1'b0, 1'b1, 400, 3, 100};
    vecs[4] = '{1100, 1'b0, 1'b1, 300, 4, 75};
    vecs[5] = '{400,  1'b0, 1'b0, 0,   0, 0};
    vecs[6] = '{400,  1'b0, 1'b1, 400, 4, 100};

    rst = 1'b0;
    bus.fanclk = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_async", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    fork
      monitor();
    join_none

    repeat (50) @(negedge clk);
    check("idle_50_cycles", all_outs(), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of a revolution while col_idx is 2.
    rv = '{250, 1'b0, 1'b1, 400, 3, 100};
    c = cyc;
    push_exp(c, rv);
    bus.fanclk = 1'b1;
    @(negedge clk);
    bus.fanclk = 1'b0;
    while (cyc < c + rv.gap) @(negedge clk);
    check("mid_rev_col_idx", 64'(bus.col_idx), 64'd2);
    #2 rst = 1'b1;
    #1 check("reset_mid_rev", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_vec('{400, 1'b0, 1'b0, 0, 0, 0});
    check("one_edge_not_locked", 64'(bus.locked), 64'd0);
    run_vec('{400, 1'b0, 1'b1, 400, 4, 100});

    repeat (10) @(negedge clk);
    check("events_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
